// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - EX-stage ALU with iterative signed/unsigned multiply/divide
// Valid/ready wrapped; mul/div take one radix-2 step per cycle in CALC.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALU_ctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_signed;
  logic             r_is_div;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_res_lo;
  logic [WIDTH-1:0] r_res_hi;
  logic             r_zero;
  logic             r_ovf;
  logic             r_dbz;
  logic             r_out_valid;
  logic             r_in_ready;

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_dif;
  logic [WIDTH-1:0]   w_alu_lo;
  logic               w_alu_ovf;
  logic               w_alu_known;
  logic               w_is_md;
  logic               w_in_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_mul_hi;
  logic [WIDTH-1:0]   w_mul_lo;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_rem;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_q_s;
  logic [WIDTH-1:0]   w_rem_s;
  logic               w_b_zero;
  logic               w_div_ovf;

  always_comb begin
    w_sum       = a + b;
    w_dif       = a - b;
    w_alu_lo    = '0;
    w_alu_ovf   = 1'b0;
    w_alu_known = 1'b1;
    case (ALU_ctl)
      OP_AND:  w_alu_lo = a & b;
      OP_OR:   w_alu_lo = a | b;
      OP_NOR:  w_alu_lo = ~(a | b);
      OP_ADD: begin
        w_alu_lo  = w_sum;
        w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_lo  = w_dif;
        w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  w_alu_lo = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: w_alu_lo = WIDTH'(a < b);
      default: w_alu_known = 1'b0;
    endcase
  end

  // 1000..1011 are mul/div; bit0 selects unsigned, bit1 selects divide
  assign w_is_md     = ALU_ctl[3] & ~ALU_ctl[2];
  assign w_in_signed = ~ALU_ctl[0];
  assign w_abs_a     = (w_in_signed && a[WIDTH-1]) ? -a : a;
  assign w_abs_b     = (w_in_signed && b[WIDTH-1]) ? -b : b;

  // Shift-add multiply: r_lo holds the multiplier and fills with product bits
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

  // Restoring divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_mcand};
  assign w_q     = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_rem   = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];

  assign w_neg_a   = r_signed & r_a[WIDTH-1];
  assign w_neg_b   = r_signed & r_b[WIDTH-1];
  assign w_prod    = {w_mul_hi, w_mul_lo};
  assign w_prod_s  = (w_neg_a ^ w_neg_b) ? -w_prod : w_prod;
  assign w_q_s     = (w_neg_a ^ w_neg_b) ? -w_q : w_q;
  assign w_rem_s   = w_neg_a ? -w_rem : w_rem;
  assign w_b_zero  = (r_b == '0);
  assign w_div_ovf = r_signed && (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&r_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_signed    <= 1'b0;
      r_is_div    <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_mcand     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_res_lo    <= '0;
      r_res_hi    <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_dbz       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            if (w_is_md) begin
              r_signed <= w_in_signed;
              r_is_div <= ALU_ctl[1];
              r_a      <= a;
              r_b      <= b;
              r_mcand  <= w_abs_b;
              r_lo     <= w_abs_a;
              r_hi     <= '0;
              r_cnt    <= '0;
              r_state  <= S_CALC;
            end else begin
              r_res_lo    <= w_alu_lo;
              r_res_hi    <= '0;
              r_zero      <= w_alu_known && (w_alu_lo == '0);
              r_ovf       <= w_alu_ovf;
              r_dbz       <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_q;
          end else begin
            r_hi <= w_mul_hi;
            r_lo <= w_mul_lo;
          end
          // Last step: sign-correct the step result directly into the outputs
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
            if (!r_is_div) begin
              r_res_lo <= w_prod_s[WIDTH-1:0];
              r_res_hi <= w_prod_s[2*WIDTH-1:WIDTH];
              r_zero   <= (w_prod_s == '0);
              r_ovf    <= 1'b0;
              r_dbz    <= 1'b0;
            end else if (w_b_zero) begin
              r_res_lo <= '1;
              r_res_hi <= r_a;
              r_zero   <= 1'b0;
              r_ovf    <= 1'b0;
              r_dbz    <= 1'b1;
            end else begin
              r_res_lo <= w_q_s;
              r_res_hi <= w_rem_s;
              r_zero   <= (w_q_s == '0);
              r_ovf    <= w_div_ovf;
              r_dbz    <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign result_lo   = r_res_lo;
  assign result_hi   = r_res_hi;
  assign zero        = r_zero;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - directed self-checking bench for alu_mdu
// Vector tables per feature with hand-computed results, latency and handshake checks.
module tb_alu_mdu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_ctl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        zero;
  logic        overflow;
  logic        div_by_zero;

  int checks;
  int failures;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        ov;
    logic        dz;
  } vec_t;

  vec_t alu_tab[9];
  vec_t mul_tab[4];
  vec_t div_tab[7];

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ALU_ctl(alu_ctl), .out_valid(out_valid), .out_ready(out_ready),
    .result_lo(result_lo), .result_hi(result_hi), .zero(zero),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for out_valid; lat counts edges from the accepting edge
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] ictl,
                        output int lat, output bit rdy_seen);
    a = ia; b = ib; alu_ctl = ictl; in_valid = 1'b1;
    rdy_seen = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; alu_ctl = '0;
    repeat (3) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({result_hi, result_lo} !== 64'd0) begin failures++; $display("FAIL reset_results got=%h exp=0", {result_hi, result_lo}); end
    checks++; if ({zero, overflow, div_by_zero} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {zero, overflow, div_by_zero}); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_alu();
    int  lat;
    bit  rdy;
    alu_tab[0] = '{32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0};
    alu_tab[1] = '{32'h00000005, 32'h00000005, 4'b0110, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0};
    alu_tab[2] = '{32'hFFFFFFFF, 32'h00000001, 4'b0111, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0};
    alu_tab[3] = '{32'hFFFFFFFF, 32'h00000001, 4'b0011, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0};
    alu_tab[4] = '{32'hF0F000FF, 32'h0FF00F0F, 4'b0000, 32'h00F0000F, 32'h0, 1'b0, 1'b0, 1'b0};
    alu_tab[5] = '{32'hF0F000FF, 32'h0FF00F0F, 4'b0001, 32'hFFF00FFF, 32'h0, 1'b0, 1'b0, 1'b0};
    alu_tab[6] = '{32'h0F0F0F0F, 32'h00FF00FF, 4'b1100, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1'b0};
    alu_tab[7] = '{32'h80000000, 32'h00000001, 4'b0110, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0};
    alu_tab[8] = '{32'h00000001, 32'h00000001, 4'b0100, 32'h00000000, 32'h0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      run_op(alu_tab[i].a, alu_tab[i].b, alu_tab[i].ctl, lat, rdy);
      checks++; if (lat !== 1) begin failures++; $display("FAIL alu%0d_latency got=%0d exp=1", i, lat); end
      checks++; if (result_lo !== alu_tab[i].lo) begin failures++; $display("FAIL alu%0d_lo got=%h exp=%h", i, result_lo, alu_tab[i].lo); end
      checks++; if (result_hi !== alu_tab[i].hi) begin failures++; $display("FAIL alu%0d_hi got=%h exp=%h", i, result_hi, alu_tab[i].hi); end
      checks++; if ({zero, overflow, div_by_zero} !== {alu_tab[i].z, alu_tab[i].ov, alu_tab[i].dz})
        begin failures++; $display("FAIL alu%0d_flags got=%b exp=%b", i, {zero, overflow, div_by_zero}, {alu_tab[i].z, alu_tab[i].ov, alu_tab[i].dz}); end
      consume();
      checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL alu%0d_return_idle got=%b exp=10", i, {in_ready, out_valid}); end
    end
  endtask

  task automatic test_mul();
    int  lat;
    bit  rdy;
    mul_tab[0] = '{32'hFFFFFFFD, 32'h00000005, 4'b1000, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    mul_tab[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1001, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    mul_tab[2] = '{32'h00000000, 32'h00001234, 4'b1000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
    mul_tab[3] = '{32'h80000000, 32'h80000000, 4'b1000, 32'h00000000, 32'h40000000, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_op(mul_tab[i].a, mul_tab[i].b, mul_tab[i].ctl, lat, rdy);
      checks++; if (lat !== 33) begin failures++; $display("FAIL mul%0d_latency got=%0d exp=33", i, lat); end
      checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL mul%0d_in_ready_busy got=%b exp=0", i, rdy); end
      checks++; if (result_lo !== mul_tab[i].lo) begin failures++; $display("FAIL mul%0d_lo got=%h exp=%h", i, result_lo, mul_tab[i].lo); end
      checks++; if (result_hi !== mul_tab[i].hi) begin failures++; $display("FAIL mul%0d_hi got=%h exp=%h", i, result_hi, mul_tab[i].hi); end
      checks++; if ({zero, overflow, div_by_zero} !== {mul_tab[i].z, mul_tab[i].ov, mul_tab[i].dz})
        begin failures++; $display("FAIL mul%0d_flags got=%b exp=%b", i, {zero, overflow, div_by_zero}, {mul_tab[i].z, mul_tab[i].ov, mul_tab[i].dz}); end
      consume();
    end
  endtask

  task automatic test_div();
    int  lat;
    bit  rdy;
    div_tab[0] = '{32'hFFFFFFF9, 32'h00000002, 4'b1010, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    div_tab[1] = '{32'h00000007, 32'h00000002, 4'b1011, 32'h00000003, 32'h00000001, 1'b0, 1'b0, 1'b0};
    div_tab[2] = '{32'h80000000, 32'hFFFFFFFF, 4'b1010, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    div_tab[3] = '{32'h00000005, 32'h00000000, 4'b1011, 32'hFFFFFFFF, 32'h00000005, 1'b0, 1'b0, 1'b1};
    div_tab[4] = '{32'hFFFFFFF8, 32'h00000000, 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b1};
    div_tab[5] = '{32'h00000007, 32'hFFFFFFFE, 4'b1010, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0, 1'b0};
    div_tab[6] = '{32'h00000001, 32'h00000005, 4'b1011, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      run_op(div_tab[i].a, div_tab[i].b, div_tab[i].ctl, lat, rdy);
      checks++; if (lat !== 33) begin failures++; $display("FAIL div%0d_latency got=%0d exp=33", i, lat); end
      checks++; if (result_lo !== div_tab[i].lo) begin failures++; $display("FAIL div%0d_lo got=%h exp=%h", i, result_lo, div_tab[i].lo); end
      checks++; if (result_hi !== div_tab[i].hi) begin failures++; $display("FAIL div%0d_hi got=%h exp=%h", i, result_hi, div_tab[i].hi); end
      checks++; if ({zero, overflow, div_by_zero} !== {div_tab[i].z, div_tab[i].ov, div_tab[i].dz})
        begin failures++; $display("FAIL div%0d_flags got=%b exp=%b", i, {zero, overflow, div_by_zero}, {div_tab[i].z, div_tab[i].ov, div_tab[i].dz}); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit rdy;
    run_op(32'd3, 32'd5, 4'b0110, lat, rdy);
    checks++; if (lat !== 1) begin failures++; $display("FAIL bp_latency got=%0d exp=1", lat); end
    for (int i = 0; i < 5; i++) begin
      a = 32'd100 + i; b = 32'd7; alu_ctl = 4'b0010; in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (result_lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL bp_hold_lo cycle=%0d got=%h exp=fffffffe", i, result_lo); end
      checks++; if ({out_valid, in_ready} !== 2'b10) begin failures++; $display("FAIL bp_hold_hs cycle=%0d got=%b exp=10", i, {out_valid, in_ready}); end
    end
    in_valid = 1'b0;
    consume();
    checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL bp_release got=%b exp=01", {out_valid, in_ready}); end
    checks++; if (result_lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL bp_no_new_accept got=%h exp=fffffffe", result_lo); end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    bit rdy;
    bit saw_valid;
    a = 32'hFFFFFFFF; b = 32'h12345678; alu_ctl = 4'b1001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
    checks++; if ({result_hi, result_lo} !== 64'd0) begin failures++; $display("FAIL rmid_results got=%h exp=0", {result_hi, result_lo}); end
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%b exp=0", saw_valid); end
    run_op(32'd2, 32'd3, 4'b0010, lat, rdy);
    checks++; if (lat !== 1) begin failures++; $display("FAIL rmid_add_latency got=%0d exp=1", lat); end
    checks++; if (result_lo !== 32'd5) begin failures++; $display("FAIL rmid_add_lo got=%h exp=5", result_lo); end
    consume();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_calc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
